// File: rtl/button_gesture_decoder_pkg.sv
// button_pkg: shared FSM state and gesture code definitions for the gesture decoder
package button_pkg;

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

    typedef logic [1:0] gesture_t;

    localparam gesture_t GEST_NONE   = 2'b00;
    localparam gesture_t GEST_SHORT  = 2'b01;
    localparam gesture_t GEST_DOUBLE = 2'b10;
    localparam gesture_t GEST_LONG   = 2'b11;

endpackage

// File: rtl/button_gesture_decoder_timer.sv
// gesture_timer: clearable, enabled up-counter with an equality compare against a runtime limit
module gesture_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    // count while enabled; a clear always wins so each state starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_gesture_decoder.sv
// button_gesture_decoder: classifies debounced presses as short/double/long and ticks auto-repeat while long-held
module button_gesture_decoder import button_pkg::*; #(
    parameter int LONG_CYCLES    = 1000,
    parameter int DBL_GAP_CYCLES = 300,
    parameter int REPEAT_CYCLES  = 100,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_state,
    input  logic       pb_down,
    input  logic       pb_up,
    output logic       gesture_valid,
    output logic [1:0] gesture,
    output logic       repeat_pulse,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, nxt_state;
    gesture_t         nxt_gesture;
    logic             nxt_valid, nxt_rep;
    logic             rel, hit, clr, en;
    logic [CNT_W-1:0] limit;

    // a lost pb_up pulse is recovered from the level falling while held
    assign rel   = pb_up | ~pb_state;
    assign en    = (state == PRESS1) | (state == WAIT2) | (state == LONG);
    assign limit = (state == PRESS1) ? LONG_LIM : (state == WAIT2) ? DBL_LIM : REP_LIM;
    assign clr   = (nxt_state != state) | nxt_rep;

    gesture_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .limit (limit),
        .hit   (hit)
    );

    // next state and next outputs; input pulses take priority over the timer compare
    always_comb begin
        nxt_state   = state;
        nxt_valid   = 1'b0;
        nxt_gesture = GEST_NONE;
        nxt_rep     = 1'b0;
        case (state)
            IDLE:   if (pb_down) nxt_state = PRESS1;
            PRESS1: begin
                if (rel) begin
                    nxt_state = WAIT2;
                end else if (hit) begin
                    nxt_state   = LONG;
                    nxt_valid   = 1'b1;
                    nxt_gesture = GEST_LONG;
                end
            end
            WAIT2: begin
                if (pb_down) begin
                    nxt_state = PRESS2;
                end else if (hit) begin
                    nxt_state   = IDLE;
                    nxt_valid   = 1'b1;
                    nxt_gesture = GEST_SHORT;
                end
            end
            PRESS2: begin
                if (rel) begin
                    nxt_state   = IDLE;
                    nxt_valid   = 1'b1;
                    nxt_gesture = GEST_DOUBLE;
                end
            end
            LONG: begin
                if (rel)
                    nxt_state = IDLE;
                else
                    nxt_rep = hit;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // state and all outputs registered together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            gesture_valid <= 1'b0;
            gesture       <= GEST_NONE;
            repeat_pulse  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= nxt_state;
            gesture_valid <= nxt_valid;
            gesture       <= nxt_gesture;
            repeat_pulse  <= nxt_rep;
            busy          <= (nxt_state != IDLE);
        end
    end

endmodule
